// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one 4x4 signed Booth multiplier between N_REQ requesters.
// Optional completed-result counter enabled by defining BOOTH_ARB_STATS_EN.

module booth_mul (
  input  logic signed [3:0] m,
  input  logic signed [3:0] q,
  output logic signed [7:0] p
);
  logic [4:0]        qe;
  logic signed [7:0] mx;
  logic signed [7:0] acc;

  assign qe = {q, 1'b0};
  assign mx = 8'(m);

  // Radix-2 Booth recoding: digit i is qe[i] - qe[i+1]
  always_comb begin
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      case (qe[i+1 -: 2])
        2'b01:   acc = acc + (mx <<< i);
        2'b10:   acc = acc - (mx <<< i);
        default: acc = acc;
      endcase
    end
  end

  assign p = acc;
endmodule

module booth_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [4*N_REQ-1:0] req_m,
  input  logic [4*N_REQ-1:0] req_q,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [7:0]         res_prod,
  output logic [ID_W-1:0]    res_id,
  output logic               busy,
  output logic [15:0]        op_count
);
  typedef enum logic [1:0] {IDLE, MUL, HOLD} st_t;

  st_t             state;
  logic [ID_W-1:0] rr_ptr, win;
  logic            any;
  int              idx;
  logic [3:0]      op_m, op_q;
  logic [7:0]      mul_p, prod_q;
  logic [1:0]      vld_pipe;
  logic [N_REQ-1:0] one;

  // First valid requester at or above rr_ptr, wrapping
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        win = ID_W'(idx);
      end
    end
  end

  assign one       = {{(N_REQ-1){1'b0}}, 1'b1};
  assign req_ready = (state == IDLE && any) ? (one << win) : '0;
  assign busy      = (state != IDLE);

  booth_mul u_mul (.m(op_m), .q(op_q), .p(mul_p));

  // Multiplier output is registered once (prod_q) before res_prod, so MUL spans two edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_m      <= '0;
      op_q      <= '0;
      prod_q    <= '0;
      vld_pipe  <= '0;
      res_valid <= 1'b0;
      res_prod  <= '0;
      res_id    <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          op_m     <= req_m[{win, 2'b00} +: 4];
          op_q     <= req_q[{win, 2'b00} +: 4];
          res_id   <= win;
          rr_ptr   <= (win == ID_W'(N_REQ-1)) ? '0 : win + 1'b1;
          vld_pipe <= 2'b01;
          state    <= MUL;
        end
        MUL: begin
          vld_pipe <= {vld_pipe[0], 1'b0};
          prod_q   <= mul_p;
          if (vld_pipe[1]) begin
            res_prod  <= prod_q;
            res_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BOOTH_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     op_count <= '0;
    else if (res_valid && res_ready) op_count <= op_count + 16'd1;
  end
`else
  assign op_count = 16'h0000;
`endif
endmodule
